mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Shares one 2:1 data mux between two valid/ready source streams and drives a single registered output stream.
- Round-robin arbitration with burst limiting: the granted source keeps the path until it goes idle or has sent MAX_BURST beats while the other source waits.
- The mux select is derived from the FSM state.
- Sits between two producers and one consumer in the datapath.

Parameters:
- DATA_W, 8, width of each data stream.
- MAX_BURST, 4, maximum consecutive beats granted to one source while the other is requesting. Must be 1 or more.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in0_valid  input  1  source 0 has data
- in0_data  input  DATA_W  source 0 data
- in0_ready  output  1  source 0 beat accepted this cycle when high with in0_valid
- in1_valid  input  1  source 1 has data
- in1_data  input  DATA_W  source 1 data
- in1_ready  output  1  source 1 accept
- out_valid  output  1  output register holds a beat
- out_data  output  DATA_W  registered output data
- out_src  output  1  source index of the beat in out_data
- out_ready  input  1  consumer accepts the output beat
- grant  output  2  one-hot current grant (00 in IDLE)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, out_valid=0, out_data=0, out_src=0, beat count=0, last-served pointer=1 (so source 0 wins first).
  - Any beat held in the output register at reset is discarded.
- Load enable: ld = !out_valid || out_ready.
  - in0_ready = ld && state==GRANT0.
  - in1_ready = ld && state==GRANT1.
  - Both readies are never high together. Both are 0 in IDLE.
- Transfer: xfer = ready && valid of the granted source.
  - On xfer, at the edge: out_data <= mux(sel, in0_data, in1_data), out_src <= sel, out_valid <= 1.
  - sel = 1 in GRANT1, else 0.
  - If ld && !xfer: out_valid <= 0.
  - If !ld: the output register holds.
  - Latency: 1 cycle from input handshake to out_valid.
  - Throughput: 1 beat per cycle while out_ready=1.
- States: IDLE, GRANT0, GRANT1 (2-bit encoding).
  - grant = 01 in GRANT0, 10 in GRANT1, 00 in IDLE.
- IDLE:
  - If only one source is valid, go to that source's GRANT.
  - If both are valid, go to the source != last.
  - If neither is valid, stay.
  - Count <= 0.
  - An arbitration decision costs one cycle; no transfer happens in IDLE.
- GRANTx, let "other" = the non-granted source:
  - Current source invalid (in_valid=0): last <= x, count <= 0. Go to GRANT(other) if other is valid, else IDLE.
  - xfer with count==MAX_BURST-1 and other valid: switch to GRANT(other), count <= 0, last <= x.
  - xfer with count==MAX_BURST-1 and other not valid: stay, count <= 0.
  - xfer otherwise: count <= count+1.
  - Current valid but stalled (!ld): stay, count holds. Grant is never revoked while a source is stalled by backpressure.
- Switching between GRANT0 and GRANT1 is direct (no IDLE bubble). The new source can transfer on the first cycle of its grant.
- Count width is $clog2(MAX_BURST+1). With MAX_BURST=1 the grant alternates every beat when both sources request.
- Sources must hold valid/data stable until accepted. The block does not check this.
- Simultaneous out_ready and xfer in the same cycle: the old beat leaves and the new beat loads in the same edge. There is no bubble.

Decomposition:
- Package mux2_arb_pkg: state encodings (ST_IDLE=2'd0, ST_G0=2'd1, ST_G1=2'd2) and the SRC0/SRC1 index constants.
- One sub-module, mux2_w: a parameterized DATA_W-wide combinational 2:1 mux (sel, a, b -> y).
- The FSM, counter and output register stay in mux2_rr_arbiter.

Test Plan:
1. Reset and single source:
   - Stimulus: rst high for 2 cycles, then in0_valid=1 with data 0x11,0x22,0x33, out_ready=1.
   - Response: grant=01 one cycle after valid. out_data 0x11,0x22,0x33 on consecutive cycles with out_src=0. State returns to IDLE after valid drops.
2. Contention and burst limit:
   - Stimulus: both sources valid continuously, MAX_BURST=4, out_ready=1.
   - Response: out_src sequence 0,0,0,0,1,1,1,1,0,...
   - Response: in0_ready and in1_ready are never high together.
3. Backpressure:
   - Stimulus: out_ready=0 for 3 cycles mid-burst.
   - Response: out_data/out_valid hold, in_ready=0, count frozen.
   - Response: no beat lost or duplicated once out_ready returns.
4. Early release:
   - Stimulus: source 0 sends 2 beats then drops valid while source 1 is valid.
   - Response: GRANT1 on the next cycle with no IDLE.
   - Response: source 1 gets a full burst of 4 beats.
5. Tie from IDLE:
   - Stimulus: both sources raise valid on the same cycle right after reset.
   - Response: source 0 is granted first.
   - Stimulus: both again from IDLE later.
   - Response: the source opposite to the last served one is granted.
6. Reset mid-operation:
   - Stimulus: assert rst while out_valid=1 and state=GRANT1.
   - Response: next cycle out_valid=0, grant=00, out_data=0.
   - Response: after release, source 0 wins a tie.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
// Shared encodings for the two-source round-robin arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/mux2_w.sv
// Parameterized combinational 2:1 data mux; sel=0 picks a, sel=1 picks b.
module mux2_w #(
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-source valid/ready arbiter with burst-limited round robin feeding one
// registered output stream through a shared 2:1 mux.
//
// state   | meaning
// IDLE    | no grant; arbitration decision taken this cycle
// GRANT0  | source 0 owns the mux path
// GRANT1  | source 1 owns the mux path
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic [1:0]        grant
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             last, last_nxt;

  logic              ld;
  logic              sel;
  logic              xfer;
  logic              cur_valid;
  logic              oth_valid;
  logic [DATA_W-1:0] mux_y;

  assign ld        = !out_valid || out_ready;
  assign sel       = (state == ST_G1);
  assign in0_ready = ld && (state == ST_G0);
  assign in1_ready = ld && (state == ST_G1);
  assign xfer      = (in0_ready && in0_valid) || (in1_ready && in1_valid);
  assign cur_valid = sel ? in1_valid : in0_valid;
  assign oth_valid = sel ? in0_valid : in1_valid;

  mux2_w #(.DATA_W(DATA_W)) u_mux (
    .sel (sel),
    .a   (in0_data),
    .b   (in1_data),
    .y   (mux_y)
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    last_nxt  = last;
    grant     = 2'b00;
    case (state)
      ST_IDLE: begin
        count_nxt = '0;
        if (in0_valid && in1_valid)
          state_nxt = (last == SRC0) ? ST_G1 : ST_G0;
        else if (in0_valid)
          state_nxt = ST_G0;
        else if (in1_valid)
          state_nxt = ST_G1;
      end
      ST_G0, ST_G1: begin
        grant = sel ? 2'b10 : 2'b01;
        if (!cur_valid) begin
          last_nxt  = sel;
          count_nxt = '0;
          if (oth_valid)
            state_nxt = sel ? ST_G0 : ST_G1;
          else
            state_nxt = ST_IDLE;
        end else if (xfer) begin
          if (count == CNT_LAST) begin
            // Burst exhausted: hand over only if the other side is waiting.
            count_nxt = '0;
            if (oth_valid) begin
              last_nxt  = sel;
              state_nxt = sel ? ST_G0 : ST_G1;
            end
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      last  <= SRC1;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      last  <= last_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_y;
      out_src   <= sel;
    end else if (ld) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: reset, single source, contention,
// backpressure, early release, tie-breaking and reset mid-operation.
module tb_mux2_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       in0_valid, in1_valid;
  logic [7:0] in0_data, in1_data;
  logic       in0_ready, in1_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_src;
  logic       out_ready;
  logic [1:0] grant;

  int checks;
  int failures;

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advances one cycle; a source steps its data after each accepted beat.
  task automatic tick();
    logic hs0, hs1;
    #1;
    hs0 = in0_valid && in0_ready;
    hs1 = in1_valid && in1_ready;
    @(posedge clk);
    #1;
    if (hs0) in0_data = in0_data + 8'd1;
    if (hs1) in1_data = in1_data + 8'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_data = 8'h10;
    in1_data = 8'h80;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || grant !== 2'b00 || out_data !== 8'h00 || out_src !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b grant=%b data=%h src=%b want 0 00 00 0",
               out_valid, grant, out_data, out_src);
    end
    checks++;
    if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b%b want 00", in0_ready, in1_ready);
    end
  endtask

  task automatic test_single_source();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    do_reset();
    in0_valid = 1'b1;
    in0_data = vals[0];
    tick();
    checks++;
    if (grant !== 2'b01 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_grant: got grant=%b valid=%b want 01 0", grant, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== vals[i] || out_src !== 1'b0) begin
        failures++;
        $display("FAIL single_beat%0d: got valid=%b data=%h src=%b want 1 %h 0",
                 i, out_valid, out_data, out_src, vals[i]);
      end
      if (i < 2) in0_data = vals[i+1];
    end
    in0_valid = 1'b0;
    tick();
    checks++;
    if (grant !== 2'b00 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: got grant=%b valid=%b want 00 0", grant, out_valid);
    end
  endtask

  // Continues from test_single_source: last served is source 0.
  task automatic test_tie_from_idle();
    in0_data = 8'h50;
    in1_data = 8'h90;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    tick();
    checks++;
    if (grant !== 2'b10 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL tie_later_grant: got grant=%b valid=%b want 10 0", grant, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b1 || out_data !== 8'h90) begin
      failures++;
      $display("FAIL tie_later_beat: got valid=%b src=%b data=%h want 1 1 90",
               out_valid, out_src, out_data);
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_contention();
    int e0, e1;
    logic       exp_src;
    logic [7:0] exp_d;
    e0 = 0; e1 = 0;
    do_reset();
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    tick();
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL tie_first_grant: got %b want 01", grant);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_src = ((i / 4) % 2) == 1;
      if (exp_src) begin exp_d = 8'(8'h80 + e1); e1++; end
      else         begin exp_d = 8'(8'h10 + e0); e0++; end
      checks++;
      if (out_valid !== 1'b1 || out_src !== exp_src || out_data !== exp_d) begin
        failures++;
        $display("FAIL contention_beat%0d: got valid=%b src=%b data=%h want 1 %b %h",
                 i, out_valid, out_src, out_data, exp_src, exp_d);
      end
      checks++;
      if (in0_ready && in1_ready) begin
        failures++;
        $display("FAIL ready_exclusive%0d: got in0_ready=1 in1_ready=1 want not both", i);
      end
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_after [4];
    logic       src_after [4];
    exp_after[0] = 8'h12; exp_after[1] = 8'h13; exp_after[2] = 8'h80; exp_after[3] = 8'h81;
    src_after[0] = 1'b0;  src_after[1] = 1'b0;  src_after[2] = 1'b1;  src_after[3] = 1'b1;
    do_reset();
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || in0_ready !== 1'b0 ||
          in1_ready !== 1'b0 || grant !== 2'b01) begin
        failures++;
        $display("FAIL stall%0d: got valid=%b data=%h rdy=%b%b grant=%b want 1 11 00 01",
                 i, out_valid, out_data, in0_ready, in1_ready, grant);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_after[i] || out_src !== src_after[i]) begin
        failures++;
        $display("FAIL resume%0d: got valid=%b data=%h src=%b want 1 %h %b",
                 i, out_valid, out_data, out_src, exp_after[i], src_after[i]);
      end
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    tick();
  endtask

  task automatic test_early_release();
    do_reset();
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    tick();
    tick();
    tick();
    in0_valid = 1'b0;
    tick();
    checks++;
    if (grant !== 2'b10 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL release_switch: got grant=%b valid=%b want 10 0", grant, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) in0_valid = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_src !== 1'b1 || out_data !== 8'(8'h80 + i)) begin
        failures++;
        $display("FAIL release_burst%0d: got valid=%b src=%b data=%h want 1 1 %h",
                 i, out_valid, out_src, out_data, 8'(8'h80 + i));
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'h12) begin
      failures++;
      $display("FAIL release_back: got valid=%b src=%b data=%h want 1 0 12",
               out_valid, out_src, out_data);
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    in1_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || grant !== 2'b10 || out_data !== 8'h80) begin
      failures++;
      $display("FAIL midrst_setup: got valid=%b grant=%b data=%h want 1 10 80",
               out_valid, grant, out_data);
    end
    rst = 1'b1;
    in0_valid = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || grant !== 2'b00 || out_data !== 8'h00) begin
      failures++;
      $display("FAIL midrst_clear: got valid=%b grant=%b data=%h want 0 00 00",
               out_valid, grant, out_data);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL midrst_tie: got grant=%b want 01", grant);
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_data = 8'h00;
    in1_data = 8'h00;
    out_ready = 1'b1;
    test_reset();
    test_single_source();
    test_tie_from_idle();
    test_contention();
    test_backpressure();
    test_early_release();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
